wb_burst_reader: RTL and testbench

Wishbone B4 master that reads a contiguous run of 32-bit words from a Wishbone slave (frame-buffer BlockRAM or SDRAM controller) using incrementing bursts. It streams the words in order to a valid/ready consumer, typically the video pixel pipeline. An internal FIFO absorbs consumer stalls. A burst is issued only when the FIFO can hold every beat of that burst, so the bus never stalls on back-pressure.

---
 rtl/wb_pkg.sv | 7 +
 rtl/wshb_if.sv | 15 +
 rtl/fifo_sync.sv | 49 ++++
 rtl/wb_burst_reader.sv | 151 +++++++++++++++
 tb/tb_wb_burst_reader.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Wishbone B4 constants shared by the bus masters in this codebase.
package wb_pkg;
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 read-side bus bundle with master and slave views.
interface wshb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_sm;
    logic        ack;

    modport master (output cyc, stb, we, adr, sel, cti, bte, input dat_sm, ack);
    modport slave  (input cyc, stb, we, adr, sel, cti, bte, output dat_sm, ack);
endinterface

// File: rtl/fifo_sync.sv
// Single-clock first-word fall-through FIFO; DEPTH must be a power of two.
module fifo_sync #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rd_data,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           empty,
    output logic                           full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign level   = count;
    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone incrementing-burst reader streaming a contiguous word range to a
// valid/ready consumer; a burst starts only when the FIFO can take all its beats.
module wb_burst_reader
    import wb_pkg::*;
#(
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_adr,
    input  logic [23:0] nb_words,
    output logic        busy,
    output logic        done,
    wshb_if.master      wb_m,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int unsigned BW = $clog2(BURST_LEN + 1);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   adr_q, adr_d;
    logic [23:0]   rem_q, rem_d;
    logic [BW-1:0] beats_q, beats_d;
    logic [2:0]    cti_q, cti_d;
    logic          cyc_q, cyc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [LW-1:0] level;
    logic          fifo_empty;
    logic          fifo_full;
    logic [BW-1:0] burst_beats;
    logic          space_ok;
    logic          push;

    assign burst_beats = (rem_q >= 24'(BURST_LEN)) ? BW'(BURST_LEN) : BW'(rem_q);
    assign space_ok    = ((32'(level) + 32'(burst_beats)) <= 32'(FIFO_DEPTH)) && !fifo_full;
    assign push        = cyc_q & wb_m.ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            cti_q   <= CTI_CLASSIC;
            cyc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            rem_q   <= rem_d;
            beats_q <= beats_d;
            cti_q   <= cti_d;
            cyc_q   <= cyc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        beats_d = beats_q;
        cti_d   = cti_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    adr_d   = base_adr & ~32'h3;
                    rem_d   = nb_words;
                    state_d = WAIT_SPACE;
                end
            end
            WAIT_SPACE: begin
                // A zero-length request also passes through here so done lands in cycle 2.
                if (rem_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (space_ok) begin
                    state_d = BURST;
                    cyc_d   = 1'b1;
                    beats_d = burst_beats;
                    cti_d   = (burst_beats == BW'(1)) ? CTI_EOB : CTI_INCR;
                end
            end
            BURST: begin
                if (wb_m.ack) begin
                    adr_d   = adr_q + 32'd4;
                    rem_d   = rem_q - 24'd1;
                    beats_d = beats_q - BW'(1);
                    if (beats_q == BW'(1)) begin
                        cyc_d = 1'b0;
                        cti_d = CTI_CLASSIC;
                        if (rem_q == 24'd1) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = WAIT_SPACE;
                        end
                    end else begin
                        cti_d = (beats_q == BW'(2)) ? CTI_EOB : CTI_INCR;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wb_m.cyc = cyc_q;
    assign wb_m.stb = cyc_q;
    assign wb_m.we  = 1'b0;
    assign wb_m.adr = adr_q;
    assign wb_m.sel = {4{cyc_q}};
    assign wb_m.cti = cti_q;
    assign wb_m.bte = BTE_LINEAR;
    assign busy     = busy_q;
    assign done     = done_q;
    assign out_valid = ~fifo_empty;

    fifo_sync #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (wb_m.dat_sm),
        .pop     (out_ready),
        .rd_data (out_data),
        .level   (level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );
endmodule

// File: tb/tb_wb_burst_reader.sv
// Bench for wb_burst_reader: Wishbone slave model with random wait states,
// beat-level address/cti model and an output-stream scoreboard.
module tb_wb_burst_reader;
    import wb_pkg::*;

    localparam int unsigned BL = 16;
    localparam int unsigned FD = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_adr = '0;
    logic [23:0] nb_words = '0;
    logic        busy;
    logic        done;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    wshb_if bus();

    wb_burst_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr),
        .nb_words(nb_words), .busy(busy), .done(done), .wb_m(bus),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Reference model state, advanced by the slave on every beat it acks.
    logic [31:0] exp_adr = '0;
    int unsigned exp_rem = 0, cur_len = 0, beat = 0, bursts = 0, last_len = 0;
    int unsigned acks = 0, pops = 0, max_occ = 0, done_cnt = 0;
    int unsigned max_delay = 0, wait_cnt = 0;
    bit          in_burst = 0, just_ended = 0, holding = 0, cyc_seen = 0, rand_ready = 0;
    logic [31:0] hold_adr;
    logic [2:0]  hold_cti;
    logic [31:0] sb[$];

    // Wishbone slave: decides ack on the falling edge, checked by the DUT on the rising edge.
    initial begin
        bus.ack = 1'b0;
        bus.dat_sm = '0;
        forever begin
            @(negedge clk);
            bus.ack = 1'b0;
            if (!rst_n) begin
                wait_cnt = 0; holding = 0; beat = 0; in_burst = 0; just_ended = 0;
                continue;
            end
            if (bus.cyc) cyc_seen = 1;
            if (just_ended) begin
                chk("gap_between_bursts", {31'b0, bus.cyc}, 32'd0);
                just_ended = 0;
            end
            if (bus.cyc && bus.stb) begin
                if (!in_burst) begin
                    in_burst = 1;
                    bursts++;
                    chk("burst_has_work", {31'b0, exp_rem != 0}, 32'd1);
                    cur_len = (exp_rem < BL) ? exp_rem : BL;
                end
                if (holding) begin
                    chk("hold_adr", bus.adr, hold_adr);
                    chk("hold_cti", {29'b0, bus.cti}, {29'b0, hold_cti});
                end
                if (wait_cnt != 0) begin
                    wait_cnt--;
                    if (!holding) begin
                        holding = 1; hold_adr = bus.adr; hold_cti = bus.cti;
                    end
                end else begin
                    bus.ack = 1'b1;
                    bus.dat_sm = word_at(bus.adr);
                    chk("beat_adr", bus.adr, exp_adr);
                    chk("beat_cti", {29'b0, bus.cti},
                        {29'b0, ((beat + 1 == cur_len) ? CTI_EOB : CTI_INCR)});
                    chk("beat_sel_we_bte", {25'b0, bus.sel, bus.we, bus.bte}, {25'b0, 4'hF, 1'b0, 2'b00});
                    exp_adr += 32'd4;
                    if (exp_rem != 0) exp_rem--;
                    beat++;
                    acks++;
                    holding = 0;
                    wait_cnt = $urandom_range(max_delay, 0);
                    if (beat == cur_len) begin
                        in_burst = 0; last_len = beat; beat = 0; just_ended = 1;
                    end
                end
            end else if (holding) begin
                chk("stb_held", {31'b0, bus.cyc & bus.stb}, 32'd1);
                holding = 0;
            end
        end
    end

    // Output monitor and scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) done_cnt++;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_total++;
                        $display("FAIL stream_extra: got 0x%08h expected no word", out_data);
                    end else begin
                        chk("stream_data", out_data, sb.pop_front());
                    end
                    pops++;
                end
                if (acks >= pops && acks - pops > max_occ) max_occ = acks - pops;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(3, 0) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input logic [31:0] base, input int unsigned n);
        logic [31:0] a;
        @(posedge clk); #1;
        base_adr = base; nb_words = 24'(n); start = 1'b1;
        exp_adr = base & ~32'h3; exp_rem = n; beat = 0; bursts = 0;
        in_burst = 0; done_cnt = 0; last_len = 0;
        a = exp_adr;
        for (int i = 0; i < int'(n); i++) begin
            sb.push_back(word_at(a));
            a += 32'd4;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned budget);
        bit seen = 0;
        for (int unsigned k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        chk(name, {31'b0, seen}, 32'd1);
    endtask

    task automatic wait_drain(input string name, input int unsigned budget);
        for (int unsigned k = 0; k < budget; k++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk(name, sb.size(), 32'd0);
    endtask

    typedef struct {
        logic [31:0] base;
        int unsigned n;
        int unsigned delay;
        bit          rnd_ready;
        int unsigned exp_bursts;
        int unsigned exp_last;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0000_0100,  4, 0, 0, 1,  4};
        vecs[1] = '{32'h0000_0200, 40, 0, 0, 3,  8};
        vecs[2] = '{32'h0000_0403, 17, 3, 1, 2,  1};
        vecs[3] = '{32'hFFFF_FFF8,  5, 1, 0, 1,  5};
        vecs[4] = '{32'h0000_3000, 16, 2, 1, 1, 16};
        vecs[5] = '{32'h0000_0040, 33, 0, 1, 3,  1};

        repeat (3) @(negedge clk);
        chk("rst_bus", {bus.cyc, bus.stb, bus.we, bus.sel, bus.cti, bus.bte, busy, done, out_valid, 16'b0}, '0);
        chk("rst_adr", bus.adr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First-transfer timeline: start at edge 0, acks at edges 2..5.
        start_xfer(32'h100, 4);
        @(negedge clk);
        chk("t_c1_busy", {31'b0, busy}, 32'd1);
        chk("t_c1_cyc", {31'b0, bus.cyc}, 32'd0);
        @(negedge clk);
        chk("t_c2_stb", {30'b0, bus.cyc, bus.stb}, 32'd3);
        chk("t_c2_adr", bus.adr, 32'h100);
        @(negedge clk);
        chk("t_c3_valid", {31'b0, out_valid}, 32'd1);
        chk("t_c3_data", out_data, word_at(32'h100));
        repeat (3) @(negedge clk);
        chk("t_c6_cyc_done", {30'b0, bus.cyc, done}, 32'd1);
        @(negedge clk);
        chk("t_c7_busy_done", {30'b0, busy, done}, 32'd0);
        wait_drain("t_drain", 50);

        // Zero-length request.
        cyc_seen = 0;
        start_xfer(32'h500, 0);
        @(negedge clk);
        chk("z_c1_busy_done", {30'b0, busy, done}, 32'd2);
        @(negedge clk);
        chk("z_c2_done", {31'b0, done}, 32'd1);
        @(negedge clk);
        chk("z_c3_busy", {31'b0, busy}, 32'd0);
        chk("z_no_cyc", {31'b0, cyc_seen}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            max_delay = vecs[i].delay;
            rand_ready = vecs[i].rnd_ready;
            start_xfer(vecs[i].base, vecs[i].n);
            wait_done($sformatf("v%0d_done", i), 3000);
            chk($sformatf("v%0d_busy_at_done", i), {31'b0, busy}, 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_idle", i), {30'b0, busy, bus.cyc}, 32'd0);
            chk($sformatf("v%0d_bursts", i), bursts, vecs[i].exp_bursts);
            chk($sformatf("v%0d_last_len", i), last_len, vecs[i].exp_last);
            chk($sformatf("v%0d_rem", i), exp_rem, 32'd0);
            rand_ready = 0;
            @(posedge clk); #2;
            out_ready = 1'b1;
            wait_drain($sformatf("v%0d_drain", i), 500);
            chk($sformatf("v%0d_done_pulses", i), done_cnt, 32'd1);
        end

        // A start while busy must not disturb the running transfer.
        max_delay = 1;
        start_xfer(32'h800, 20);
        repeat (6) @(posedge clk);
        #1;
        base_adr = 32'h0; nb_words = 24'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("bs_done", 500);
        @(negedge clk);
        chk("bs_bursts", bursts, 32'd2);
        chk("bs_last_len", last_len, 32'd4);
        wait_drain("bs_drain", 200);
        repeat (5) @(negedge clk);
        chk("bs_done_pulses", done_cnt, 32'd1);

        // Back-pressure: only a FIFO's worth is fetched until the consumer drains.
        max_delay = 0;
        out_ready = 1'b0;
        acks = 0; pops = 0;
        start_xfer(32'h1000, 100);
        repeat (200) @(negedge clk);
        chk("bp_acks_stalled", acks, 32'd64);
        chk("bp_cyc_idle", {31'b0, bus.cyc}, 32'd0);
        chk("bp_busy", {31'b0, busy}, 32'd1);
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_done("bp_done", 1000);
        wait_drain("bp_drain", 500);
        chk("bp_pops", pops, 32'd100);
        chk("bp_acks", acks, 32'd100);

        // Asynchronous reset on beat 5, then a clean transfer.
        acks = 0;
        start_xfer(32'h2000, 32);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (acks >= 5) break;
        end
        chk("rr_reached_beat5", {31'b0, acks >= 5}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_async", {28'b0, bus.cyc, bus.stb, out_valid, busy}, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        start_xfer(32'h2400, 6);
        wait_done("rr_done", 200);
        chk("rr_bursts", bursts, 32'd1);
        chk("rr_last_len", last_len, 32'd6);
        wait_drain("rr_drain", 100);

        chk("fifo_no_overflow", {31'b0, max_occ <= FD}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
